// File: rtl/arcade_ram_arbiter.sv
// rtl/arcade_ram_arbiter.sv - Arcade Card RAM port arbiter: CPU priority, bounded DMA starvation
module arcade_ram_arbiter #(
  parameter int STARVE_MAX = 8
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CPU_CS_N,
  input  logic [20:0] CPU_A,
  input  logic        CPU_WR_N,
  input  logic        CPU_RD_N,
  input  logic [7:0]  CPU_DI,
  output logic [7:0]  CPU_DO,
  output logic        CPU_RDY,
  input  logic        DMA_REQ,
  input  logic        DMA_WE,
  input  logic [20:0] DMA_A,
  input  logic [7:0]  DMA_DI,
  output logic [7:0]  DMA_DO,
  output logic        DMA_ACK,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [20:0] MEM_A,
  output logic [7:0]  MEM_DO,
  input  logic [7:0]  MEM_DI,
  input  logic        MEM_ACK
);

  typedef enum logic [1:0] {S_IDLE, S_CPU_BUSY, S_DMA_BUSY, S_DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_old_acc;
  logic        r_cpu_pend;
  logic        r_cpu_we;
  logic [20:0] r_cpu_a;
  logic [7:0]  r_cpu_di;
  logic [7:0]  r_starve;
  logic [7:0]  r_cpu_do;
  logic        r_cpu_rdy;
  logic [7:0]  r_dma_do;
  logic        r_dma_ack;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [20:0] r_mem_a;
  logic [7:0]  r_mem_do;

  logic w_acc;
  logic w_cpu_edge;
  logic w_starve_hit;
  logic w_enter_cpu;
  logic w_enter_dma;
  logic w_cpu_done;
  logic w_dma_done;

  assign w_acc        = ~(CPU_WR_N & CPU_RD_N);
  assign w_cpu_edge   = w_acc & ~r_old_acc & ~CPU_CS_N & ~r_cpu_pend;
  assign w_starve_hit = (r_starve >= 8'(STARVE_MAX));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // A CPU edge seen in IDLE holds the grant one cycle so the CPU keeps
  // priority over a DMA_REQ arriving in the same cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (DMA_REQ && w_starve_hit)     w_next = S_DMA_BUSY;
        else if (r_cpu_pend)             w_next = S_CPU_BUSY;
        else if (DMA_REQ && !w_cpu_edge) w_next = S_DMA_BUSY;
      end
      S_CPU_BUSY: if (MEM_ACK) w_next = S_DONE;
      S_DMA_BUSY: if (MEM_ACK) w_next = S_DONE;
      S_DONE:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_enter_cpu = 1'b0;
    w_enter_dma = 1'b0;
    w_cpu_done  = 1'b0;
    w_dma_done  = 1'b0;
    if (r_state == S_IDLE) begin
      w_enter_cpu = (w_next == S_CPU_BUSY);
      w_enter_dma = (w_next == S_DMA_BUSY);
    end
    if (r_state == S_CPU_BUSY) w_cpu_done = MEM_ACK;
    if (r_state == S_DMA_BUSY) w_dma_done = MEM_ACK;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_old_acc  <= 1'b1;
      r_cpu_pend <= 1'b0;
      r_cpu_we   <= 1'b0;
      r_cpu_a    <= '0;
      r_cpu_di   <= '0;
      r_starve   <= '0;
      r_cpu_do   <= 8'hFF;
      r_cpu_rdy  <= 1'b1;
      r_dma_do   <= '0;
      r_dma_ack  <= 1'b0;
      r_mem_req  <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_a    <= '0;
      r_mem_do   <= '0;
    end else begin
      r_old_acc <= w_acc;
      r_dma_ack <= w_dma_done;
      if (w_cpu_edge) begin
        r_cpu_pend <= 1'b1;
        r_cpu_a    <= CPU_A;
        r_cpu_di   <= CPU_DI;
        r_cpu_we   <= ~CPU_WR_N;
        r_cpu_rdy  <= 1'b0;
      end
      if (w_enter_cpu) begin
        r_mem_req <= 1'b1;
        r_mem_we  <= r_cpu_we;
        r_mem_a   <= r_cpu_a;
        r_mem_do  <= r_cpu_di;
      end
      if (w_enter_dma) begin
        r_mem_req <= 1'b1;
        r_mem_we  <= DMA_WE;
        r_mem_a   <= DMA_A;
        r_mem_do  <= DMA_DI;
      end
      if (w_cpu_done) begin
        r_mem_req  <= 1'b0;
        r_cpu_pend <= 1'b0;
        r_cpu_rdy  <= 1'b1;
        if (!r_mem_we) r_cpu_do <= MEM_DI;
      end
      if (w_dma_done) begin
        r_mem_req <= 1'b0;
        if (!r_mem_we) r_dma_do <= MEM_DI;
      end
      if (!DMA_REQ || w_enter_dma)               r_starve <= '0;
      else if (w_enter_cpu && r_starve != 8'hFF) r_starve <= r_starve + 8'd1;
    end
  end

  assign CPU_DO  = r_cpu_do;
  assign CPU_RDY = r_cpu_rdy;
  assign DMA_DO  = r_dma_do;
  assign DMA_ACK = r_dma_ack;
  assign MEM_REQ = r_mem_req;
  assign MEM_WE  = r_mem_we;
  assign MEM_A   = r_mem_a;
  assign MEM_DO  = r_mem_do;

endmodule

// File: tb/tb_arcade_ram_arbiter.sv
// tb/tb_arcade_ram_arbiter.sv - scoreboard bench for arcade_ram_arbiter
module tb_arcade_ram_arbiter;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        CPU_CS_N, CPU_WR_N, CPU_RD_N;
  logic [20:0] CPU_A;
  logic [7:0]  CPU_DI, CPU_DO;
  logic        CPU_RDY;
  logic        DMA_REQ, DMA_WE, DMA_ACK;
  logic [20:0] DMA_A;
  logic [7:0]  DMA_DI, DMA_DO;
  logic        MEM_REQ, MEM_WE, MEM_ACK;
  logic [20:0] MEM_A;
  logic [7:0]  MEM_DO, MEM_DI;

  arcade_ram_arbiter #(.STARVE_MAX(8)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .CPU_CS_N(CPU_CS_N), .CPU_A(CPU_A), .CPU_WR_N(CPU_WR_N), .CPU_RD_N(CPU_RD_N),
    .CPU_DI(CPU_DI), .CPU_DO(CPU_DO), .CPU_RDY(CPU_RDY),
    .DMA_REQ(DMA_REQ), .DMA_WE(DMA_WE), .DMA_A(DMA_A), .DMA_DI(DMA_DI),
    .DMA_DO(DMA_DO), .DMA_ACK(DMA_ACK),
    .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_A(MEM_A), .MEM_DO(MEM_DO),
    .MEM_DI(MEM_DI), .MEM_ACK(MEM_ACK)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        we;
    logic [20:0] a;
    logic [7:0]  d;
  } mem_exp_t;

  mem_exp_t   exp_mem[$];
  logic [7:0] exp_cpu[$];
  logic [7:0] exp_dma[$];
  logic [7:0] mem [logic [20:0]];
  int         mem_wait = 0;
  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 'h%0h, required 'h%0h", name, act, exp);
    end
  endtask

  function automatic void push_mem(input logic we, input logic [20:0] a, input logic [7:0] d);
    mem_exp_t e;
    e.we = we;
    e.a  = a;
    e.d  = d;
    exp_mem.push_back(e);
  endfunction

  // memory controller model: ACK after mem_wait extra cycles of MEM_REQ
  initial begin
    int wcnt;
    wcnt    = 0;
    MEM_ACK = 1'b0;
    MEM_DI  = 8'h00;
    forever begin
      @(posedge CLK);
      #1;
      MEM_ACK = 1'b0;
      if (MEM_REQ) begin
        if (wcnt >= mem_wait) begin
          MEM_ACK = 1'b1;
          wcnt    = 0;
          if (MEM_WE) mem[MEM_A] = MEM_DO;
          else        MEM_DI = mem.exists(MEM_A) ? mem[MEM_A] : 8'h00;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // monitor: pops the scoreboard whenever the DUT presents a request or completion
  initial begin
    logic     p_req, p_rdy;
    int       last_ack;
    mem_exp_t e;
    p_req    = 1'b0;
    p_rdy    = 1'b1;
    last_ack = -100;
    forever begin
      @(negedge CLK);
      cyc++;
      if (!RST_N) begin
        p_req = 1'b0;
        p_rdy = 1'b1;
      end else begin
        if (MEM_REQ && !p_req) begin
          n_checks++;
          if (cyc - last_ack < 3) begin
            n_fail++;
            $display("FAIL req_gap: actual %0d edges from MEM_ACK, required >= 2", cyc - last_ack - 1);
          end
          if (exp_mem.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL mem_req_unexpected: actual request at 'h%0h, required none", MEM_A);
          end else begin
            e = exp_mem.pop_front();
            chk("mem_we", {31'd0, MEM_WE}, {31'd0, e.we});
            chk("mem_a", {11'd0, MEM_A}, {11'd0, e.a});
            if (e.we) chk("mem_do", {24'd0, MEM_DO}, {24'd0, e.d});
          end
        end
        if (CPU_RDY && !p_rdy) begin
          if (exp_cpu.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL cpu_rdy_unexpected: actual rise, required none");
          end else begin
            chk("cpu_do", {24'd0, CPU_DO}, {24'd0, exp_cpu.pop_front()});
          end
        end
        if (DMA_ACK) begin
          chk("dma_ack_latency", cyc - last_ack, 1);
          if (exp_dma.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL dma_ack_unexpected: actual pulse, required none");
          end else begin
            chk("dma_do", {24'd0, DMA_DO}, {24'd0, exp_dma.pop_front()});
          end
        end
        if (MEM_ACK) last_ack = cyc;
        p_req = MEM_REQ;
        p_rdy = CPU_RDY;
      end
    end
  end

  task automatic cpu_access(input logic cs_n, input logic wr, input logic [20:0] a,
                            input logic [7:0] d, output int lowc);
    CPU_CS_N = cs_n;
    CPU_A    = a;
    CPU_DI   = d;
    if (wr) CPU_WR_N = 1'b0;
    else    CPU_RD_N = 1'b0;
    @(posedge CLK);
    #1;
    CPU_WR_N = 1'b1;
    CPU_RD_N = 1'b1;
    lowc = 0;
    while (!CPU_RDY && lowc < 300) begin
      lowc++;
      @(posedge CLK);
      #1;
    end
    chk("cpu_rdy_seen", {31'd0, CPU_RDY}, 1);
  endtask

  task automatic dma_xfer(input logic we, input logic [20:0] a, input logic [7:0] d);
    int cnt;
    DMA_WE  = we;
    DMA_A   = a;
    DMA_DI  = d;
    DMA_REQ = 1'b1;
    cnt     = 0;
    do begin
      @(posedge CLK);
      #1;
      cnt++;
    end while (!DMA_ACK && cnt < 500);
    chk("dma_ack_seen", {31'd0, DMA_ACK}, 1);
    DMA_REQ = 1'b0;
  endtask

  logic [7:0] starve_data [9] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99};

  initial begin
    int lc;
    RST_N = 1'b0;
    CPU_CS_N = 1'b1; CPU_A = '0; CPU_WR_N = 1'b1; CPU_RD_N = 1'b1; CPU_DI = '0;
    DMA_REQ = 1'b0; DMA_WE = 1'b0; DMA_A = '0; DMA_DI = '0;
    mem[21'h012345] = 8'hA5;
    mem[21'h000100] = 8'h5A;
    for (int i = 0; i < 9; i++) mem[21'h000010 + 21'(i)] = starve_data[i];

    repeat (3) @(posedge CLK);
    #1;
    chk("rst_cpu_do", {24'd0, CPU_DO}, 32'hFF);
    chk("rst_cpu_rdy", {31'd0, CPU_RDY}, 1);
    chk("rst_dma_do", {24'd0, DMA_DO}, 0);
    chk("rst_dma_ack", {31'd0, DMA_ACK}, 0);
    chk("rst_mem_req", {31'd0, MEM_REQ}, 0);
    chk("rst_mem_we", {31'd0, MEM_WE}, 0);
    chk("rst_mem_a", {11'd0, MEM_A}, 0);
    chk("rst_mem_do", {24'd0, MEM_DO}, 0);
    @(posedge CLK);
    #2;
    RST_N = 1'b1;
    @(posedge CLK);
    #1;

    // CPU read with two wait cycles
    mem_wait = 2;
    push_mem(1'b0, 21'h012345, 8'h00);
    exp_cpu.push_back(8'hA5);
    cpu_access(1'b0, 1'b0, 21'h012345, 8'h00, lc);
    chk("cpu_rdy_low_cycles", lc, 4);

    // strobe with chip select high is a register access
    cpu_access(1'b1, 1'b1, 21'h000055, 8'hEE, lc);
    chk("cs_high_rdy_low_cycles", lc, 0);
    repeat (6) @(posedge CLK);
    #1;
    chk("cs_high_rdy", {31'd0, CPU_RDY}, 1);

    // DMA write at the top address
    mem_wait = 0;
    push_mem(1'b1, 21'h1FFFFF, 8'h3C);
    exp_dma.push_back(8'h00);
    dma_xfer(1'b1, 21'h1FFFFF, 8'h3C);
    @(posedge CLK);
    #1;
    chk("dma_ack_one_cycle", {31'd0, DMA_ACK}, 0);
    repeat (2) @(posedge CLK);
    #1;

    // DMA held high against back-to-back CPU reads: 8 CPU grants, then DMA
    mem_wait = 1;
    for (int i = 0; i < 8; i++) begin
      push_mem(1'b0, 21'h000010 + 21'(i), 8'h00);
      exp_cpu.push_back(starve_data[i]);
    end
    push_mem(1'b0, 21'h000100, 8'h00);
    push_mem(1'b0, 21'h000018, 8'h00);
    exp_cpu.push_back(starve_data[8]);
    exp_dma.push_back(8'h5A);
    fork
      begin
        int lc2;
        for (int i = 0; i < 9; i++) cpu_access(1'b0, 1'b0, 21'h000010 + 21'(i), 8'h00, lc2);
      end
      dma_xfer(1'b0, 21'h000100, 8'h00);
    join
    @(posedge CLK);
    #1;
    chk("starve_cleared", {24'd0, dut.r_starve}, 0);
    repeat (2) @(posedge CLK);
    #1;

    // simultaneous CPU edge and DMA request from idle: CPU first
    mem_wait = 0;
    push_mem(1'b1, 21'h0ABCDE, 8'h77);
    push_mem(1'b0, 21'h1FFFFF, 8'h00);
    exp_cpu.push_back(8'h99);
    exp_dma.push_back(8'h3C);
    fork
      begin
        int lc3;
        cpu_access(1'b0, 1'b1, 21'h0ABCDE, 8'h77, lc3);
      end
      dma_xfer(1'b0, 21'h1FFFFF, 8'h00);
    join
    repeat (3) @(posedge CLK);
    #1;

    // async reset while CPU_BUSY, strobe held low through release
    mem_wait = 20;
    push_mem(1'b0, 21'h000200, 8'h00);
    CPU_CS_N = 1'b0;
    CPU_A    = 21'h000200;
    CPU_RD_N = 1'b0;
    lc = 0;
    do begin
      @(posedge CLK);
      #1;
      lc++;
    end while (!MEM_REQ && lc < 10);
    chk("busy_before_reset", {31'd0, MEM_REQ}, 1);
    @(posedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    chk("reset_drops_mem_req", {31'd0, MEM_REQ}, 0);
    chk("reset_sets_cpu_rdy", {31'd0, CPU_RDY}, 1);
    repeat (2) @(posedge CLK);
    #2;
    RST_N = 1'b1;
    lc = 0;
    repeat (8) begin
      @(posedge CLK);
      #1;
      if (!CPU_RDY) lc++;
    end
    chk("held_strobe_rdy_low", lc, 0);
    CPU_RD_N = 1'b1;
    CPU_CS_N = 1'b1;
    mem_wait = 0;
    @(posedge CLK);
    #1;

    // fresh strobe after reset, zero-wait memory
    push_mem(1'b0, 21'h012345, 8'h00);
    exp_cpu.push_back(8'hA5);
    cpu_access(1'b0, 1'b0, 21'h012345, 8'h00, lc);
    chk("zero_wait_rdy_low_cycles", lc, 2);

    repeat (5) @(posedge CLK);
    #1;
    chk("exp_mem_drained", exp_mem.size(), 0);
    chk("exp_cpu_drained", exp_cpu.size(), 0);
    chk("exp_dma_drained", exp_dma.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: actual time limit reached, required $finish");
    $fatal(1);
  end

endmodule
